// File: rtl/bus_debug_bridge.sv
// rtl/bus_debug_bridge.sv - UART byte-stream to 16-bit SoC bus debug initiator
//
// Parses host frames ('W' addr16 data16 / 'R' addr16), arbitrates for the
// shared SoC bus, performs one access and returns ACK_BYTE or the read data
// (big-endian). Unknown commands answer NAK_BYTE.
//
// Optional feature macro: BUS_DEBUG_BRIDGE_TIMEOUT_EN
//   When defined, a partial frame idle for TIMEOUT_CYCLES is abandoned with NAK.
//
// Ports:
//   i_clk, i_reset_n           clock, asynchronous active-low reset
//   i_rx_valid, i_rx_data      received byte strobe (no backpressure)
//   o_tx_valid, o_tx_data,
//   i_tx_ready                 response byte stream (valid/ready)
//   o_bus_req, i_bus_gnt       bus arbitration
//   o_bus_addr, o_bus_wdata,
//   o_bus_we, i_bus_rdata      SoC bus (1-cycle read latency)
//   o_overrun                  pulse: an rx byte was dropped
//   o_busy                     frame in progress (state != IDLE)
module bus_debug_bridge #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_bus_req,
    input  logic        i_bus_gnt,
    output logic [15:0] o_bus_addr,
    output logic [15:0] o_bus_wdata,
    output logic        o_bus_we,
    input  logic [15:0] i_bus_rdata,
    output logic        o_overrun,
    output logic        o_busy
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    typedef enum logic [3:0] {
        S_IDLE, S_A_HI, S_A_LO, S_D_HI, S_D_LO, S_REQ, S_ACCESS, S_SAMPLE,
        S_TX_HI, S_TX_LO, S_TX_ACK, S_TX_NAK
    } state_t;

    state_t      state_q;
    logic [7:0]  cmd_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        bus_req_q;
    logic [15:0] bus_addr_q;
    logic [15:0] bus_wdata_q;
    logic        bus_we_q;
    logic        overrun_q;
    logic        busy_q;

    logic collecting;
    logic tx_fire;
    logic is_write;
    logic tmo_hit;

    // States in which an rx byte is consumed; anywhere else it is dropped.
    assign collecting = (state_q == S_IDLE) || (state_q == S_A_HI) || (state_q == S_A_LO) ||
                        (state_q == S_D_HI) || (state_q == S_D_LO);
    assign tx_fire    = tx_valid_q && i_tx_ready;
    assign is_write   = (cmd_q == CMD_WRITE);

`ifdef BUS_DEBUG_BRIDGE_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        in_frame;

    assign in_frame = collecting && (state_q != S_IDLE);
    assign tmo_hit  = in_frame && !i_rx_valid && (tmo_cnt_q == TIMEOUT_CYCLES - 16'd1);

    // Every exit from a collection state is via a consumed byte or a timeout,
    // both of which clear the counter, so it sits at 0 everywhere else.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_cnt_q <= 16'd0;
        end else if (!in_frame || i_rx_valid || tmo_hit) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end
`else
    logic unused_timeout;
    assign tmo_hit        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'd0;
            addr_q      <= 16'd0;
            data_q      <= 16'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= 16'd0;
            bus_wdata_q <= 16'd0;
            bus_we_q    <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            overrun_q <= i_rx_valid && !collecting;

            if (tmo_hit) begin
                state_q    <= S_TX_NAK;
                tx_valid_q <= 1'b1;
                tx_data_q  <= NAK_BYTE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_rx_valid) begin
                            busy_q <= 1'b1;
                            if (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ) begin
                                cmd_q   <= i_rx_data;
                                state_q <= S_A_HI;
                            end else begin
                                state_q    <= S_TX_NAK;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= NAK_BYTE;
                            end
                        end
                    end
                    S_A_HI: begin
                        if (i_rx_valid) begin
                            addr_q[15:8] <= i_rx_data;
                            state_q      <= S_A_LO;
                        end
                    end
                    S_A_LO: begin
                        if (i_rx_valid) begin
                            addr_q[7:0] <= i_rx_data;
                            if (is_write) begin
                                state_q <= S_D_HI;
                            end else begin
                                state_q   <= S_REQ;
                                bus_req_q <= 1'b1;
                            end
                        end
                    end
                    S_D_HI: begin
                        if (i_rx_valid) begin
                            data_q[15:8] <= i_rx_data;
                            state_q      <= S_D_LO;
                        end
                    end
                    S_D_LO: begin
                        if (i_rx_valid) begin
                            data_q[7:0] <= i_rx_data;
                            state_q     <= S_REQ;
                            bus_req_q   <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (i_bus_gnt) begin
                            state_q    <= S_ACCESS;
                            bus_addr_q <= addr_q;
                            if (is_write) begin
                                bus_wdata_q <= data_q;
                                bus_we_q    <= 1'b1;
                            end
                        end
                    end
                    S_ACCESS: begin
                        bus_we_q    <= 1'b0;
                        bus_wdata_q <= 16'd0;
                        if (is_write) begin
                            bus_req_q  <= 1'b0;
                            bus_addr_q <= 16'd0;
                            state_q    <= S_TX_ACK;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= ACK_BYTE;
                        end else begin
                            state_q <= S_SAMPLE;
                        end
                    end
                    S_SAMPLE: begin
                        // Read mux output is valid one cycle after the address.
                        data_q     <= i_bus_rdata;
                        bus_req_q  <= 1'b0;
                        bus_addr_q <= 16'd0;
                        state_q    <= S_TX_HI;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= i_bus_rdata[15:8];
                    end
                    S_TX_HI: begin
                        if (tx_fire) begin
                            state_q   <= S_TX_LO;
                            tx_data_q <= data_q[7:0];
                        end
                    end
                    S_TX_LO, S_TX_ACK, S_TX_NAK: begin
                        if (tx_fire) begin
                            state_q    <= S_IDLE;
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'd0;
                            busy_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_tx_valid  = tx_valid_q;
    assign o_tx_data   = tx_data_q;
    assign o_bus_req   = bus_req_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_bus_we    = bus_we_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_bus_debug_bridge.sv
// tb/tb_bus_debug_bridge.sv - self-checking bench for bus_debug_bridge
module tb_bus_debug_bridge;

    localparam logic [7:0]  ACK = 8'h06;
    localparam logic [7:0]  NAK = 8'h15;
    localparam int          TMO = 16;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        bus_req;
    logic        gnt = 1'b0;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic [15:0] bus_rdata = 16'd0;
    logic        overrun;
    logic        busy;

    int errors = 0;
    int checks = 0;

    bus_debug_bridge #(.TIMEOUT_CYCLES(16'(TMO)), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
        .o_bus_req(bus_req), .i_bus_gnt(gnt),
        .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_we(bus_we),
        .i_bus_rdata(bus_rdata), .o_overrun(overrun), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // SoC memory with synchronous 1-cycle read; reference memory is the bench's own view.
    bit [15:0] soc_mem [0:65535];
    bit [15:0] ref_mem [0:65535];

    always @(posedge clk) begin
        bus_rdata <= soc_mem[bus_addr];
        if (bus_we && gnt) soc_mem[bus_addr] <= bus_wdata;
    end

    // Arbiter: grants gnt_delay cycles after request, drops grant when request falls.
    int gnt_delay = 0;
    int req_cycles = 0;
    always @(posedge clk) begin
        #1;
        if (!bus_req) begin
            gnt = 1'b0;
            req_cycles = 0;
        end else begin
            if (req_cycles >= gnt_delay) gnt = 1'b1;
            req_cycles++;
        end
    end

    // Bus / overrun observers
    int          we_cnt = 0;
    int          we_no_gnt = 0;
    int          ovr_cnt = 0;
    logic [15:0] last_waddr = 16'd0;
    logic [15:0] last_wdata = 16'd0;
    always @(negedge clk) begin
        if (bus_we) begin
            we_cnt++;
            last_waddr = bus_addr;
            last_wdata = bus_wdata;
            if (!gnt) we_no_gnt++;
        end
        if (overrun) ovr_cnt++;
    end

    task automatic rx_frame(input bq_t bytes, input bit b2b);
        foreach (bytes[i]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = bytes[i];
            if (!b2b || i == bytes.size() - 1) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: ready every other cycle
    task automatic collect_tx(input int n, input int budget, input int mode, output bq_t got);
        int          cyc = 0;
        bit          held = 1'b0;
        logic [7:0]  hd = 8'd0;
        got = {};
        while (got.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== hd) begin
                    errors++;
                    $display("FAIL tx_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, hd);
                end
            end
            held = 1'b0;
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = cyc[0];
            endcase
            if (tx_valid) begin
                if (tx_ready) got.push_back(tx_data);
                else begin
                    held = 1'b1;
                    hd   = tx_data;
                end
            end
        end
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic check_resp(input string name, input bq_t got, input bq_t exp);
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("FAIL %s_len: got %0d bytes, required %0d", name, got.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %h, required %h", name, i, got[i], exp[i]);
                end
            end
        end
    endtask

    // Runs a whole frame and checks the response against the reference memory.
    task automatic do_frame(input string name, input logic [7:0] cmd, input logic [15:0] a,
                            input logic [15:0] d, input bit b2b, input int mode, input int gd);
        bq_t f, exp, got;
        gnt_delay = gd;
        if (cmd == 8'h57) begin
            f = '{cmd, a[15:8], a[7:0], d[15:8], d[7:0]};
            exp = '{ACK};
            ref_mem[a] = d;
        end else if (cmd == 8'h52) begin
            f = '{cmd, a[15:8], a[7:0]};
            exp = '{ref_mem[a][15:8], ref_mem[a][7:0]};
        end else begin
            f = '{cmd};
            exp = '{NAK};
        end
        rx_frame(f, b2b);
        collect_tx(exp.size(), 200, mode, got);
        check_resp(name, got, exp);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_valid, tx_data, bus_req, bus_addr, bus_wdata, bus_we, overrun, busy} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {tx_valid, tx_data, bus_req, bus_addr, bus_wdata, bus_we, overrun, busy});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int w0 = we_cnt;
        do_frame("write", 8'h57, 16'h0430, 16'hBEEF, 1'b0, 0, 1);
        checks++;
        if (we_cnt - w0 != 1) begin
            errors++;
            $display("FAIL write_we_cycles: got %0d, required 1", we_cnt - w0);
        end
        checks++;
        if (last_waddr !== 16'h0430 || last_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_bus: addr=%h wdata=%h, required 0430 BEEF", last_waddr, last_wdata);
        end
        checks++;
        if (we_no_gnt != 0) begin
            errors++;
            $display("FAIL write_we_gnt: we without gnt %0d times, required 0", we_no_gnt);
        end
        checks++;
        if (bus_addr !== 16'd0 || bus_wdata !== 16'd0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL write_bus_idle: addr=%h wdata=%h req=%b, required 0", bus_addr, bus_wdata, bus_req);
        end
    endtask

    task automatic test_read();
        @(negedge clk);
        soc_mem[16'h0010] = 16'h1234;
        ref_mem[16'h0010] = 16'h1234;
        do_frame("read", 8'h52, 16'h0010, 16'h0, 1'b0, 2, 3);
        do_frame("read_written", 8'h52, 16'h0430, 16'h0, 1'b1, 1, 0);
    endtask

    task automatic test_bad_cmd();
        do_frame("badcmd", 8'hAA, 16'h0, 16'h0, 1'b0, 0, 0);
        do_frame("after_bad", 8'h52, 16'h0010, 16'h0, 1'b0, 1, 2);
    endtask

    task automatic test_dropped_byte();
        bq_t f, got, exp;
        int  o0;
        soc_mem[16'h0abc] = 16'h5a6b;
        ref_mem[16'h0abc] = 16'h5a6b;
        gnt_delay = 20;
        f = '{8'h52, 8'h0a, 8'hbc};
        rx_frame(f, 1'b1);
        o0 = ovr_cnt;
        f = '{8'h00};
        rx_frame(f, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (ovr_cnt - o0 != 1) begin
            errors++;
            $display("FAIL drop_overrun: pulse cycles %0d, required 1", ovr_cnt - o0);
        end
        exp = '{8'h5a, 8'h6b};
        collect_tx(2, 200, 0, got);
        check_resp("drop_resp", got, exp);
    endtask

    task automatic test_random();
        logic [7:0]  cmd;
        logic [15:0] a, d;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    cmd = 8'h57;
                2, 3:    cmd = 8'h52;
                default: begin
                    cmd = 8'($urandom_range(0, 255));
                    if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'hFF;
                end
            endcase
            a = {8'h20, 5'd0, 3'($urandom_range(0, 7))};
            d = 16'($urandom);
            do_frame("random", cmd, a, d, 1'($urandom_range(0, 1)), 1, $urandom_range(0, 4));
        end
    endtask

    task automatic test_reset_mid();
        bq_t f;
        int  n = 0;
        bit  saw_tx = 1'b0;
        gnt_delay = 0;
        f = '{8'h57, 8'hf0, 8'h00, 8'h12, 8'h34};
        rx_frame(f, 1'b1);
        while (!bus_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus_we) begin
            errors++;
            $display("FAIL rstmid_access: bus_we=%b, required 1 within 50 cycles", bus_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_we !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: we=%b req=%b, required 0 0", bus_we, bus_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid) saw_tx = 1'b1;
        end
        tx_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || saw_tx) begin
            errors++;
            $display("FAIL rstmid_after: busy=%b tx_seen=%b, required 0 0", busy, saw_tx);
        end
    endtask

    task automatic test_timeout();
        bq_t f = '{8'h57, 8'h04};
`ifdef BUS_DEBUG_BRIDGE_TIMEOUT_EN
        bq_t got;
        int  k = 0;
        rx_frame(f, 1'b0);
        while (!tx_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != TMO || tx_data !== NAK) begin
            errors++;
            $display("FAIL timeout_nak: after %0d cycles tx=%h, required %0d cycles tx=%h", k, tx_data, TMO, NAK);
        end
        collect_tx(1, 10, 0, got);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b, required 0", busy);
        end
`else
        bit saw = 1'b0;
        rx_frame(f, 1'b0);
        tx_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_valid) saw = 1'b1;
        end
        tx_ready = 1'b0;
        checks++;
        if (saw || busy !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: tx_seen=%b busy=%b, required 0 1", saw, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
        do_frame("after_timeout", 8'h52, 16'h0430, 16'h0, 1'b0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_dropped_byte();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_debug_bridge.md
Name: bus_debug_bridge

Overview:
- Second bus initiator for the toy SoC, alongside the CPU. Turns a host byte stream from the UART receiver into 16-bit bus reads and writes on the shared SoC bus.
- Returns read data and acknowledgements to the UART transmitter.
- Requests the bus from a top-level arbiter. The arbiter stalls the CPU while `i_bus_gnt` is high.
- Used for loading RAM, peeking and poking peripherals, and board bring-up without firmware.

Parameters:
- TIMEOUT_CYCLES, 16'd50000: idle cycles between command bytes before the parser aborts. Used only with the optional feature.
- ACK_BYTE, 8'h06: byte returned after a completed write.
- NAK_BYTE, 8'h15: byte returned for an unknown command or a timeout.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_rx_valid  in  1  one-cycle strobe: new received byte. No backpressure.
- i_rx_data  in  8  received byte
- o_tx_valid  out  1  response byte valid. Held until accepted.
- o_tx_data  out  8  response byte
- i_tx_ready  in  1  transmitter can accept a byte. Transfer occurs when valid && ready.
- o_bus_req  out  1  bus request
- i_bus_gnt  in  1  bus grant from the arbiter
- o_bus_addr  out  16  bus address
- o_bus_wdata  out  16  bus write data
- o_bus_we  out  1  bus write enable
- i_bus_rdata  in  16  bus read data (the SoC read mux output)
- o_overrun  out  1  one-cycle pulse: an rx byte was dropped
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, `i_clk`. Reset is asynchronous and active-low (`i_reset_n`).
- Reset values: state IDLE. All outputs 0. Internal addr, data and cmd registers 0.
- Frame format:
  - Write: 'W'(8'h57), ADDR_HI, ADDR_LO, DATA_HI, DATA_LO. Response: ACK_BYTE.
  - Read: 'R'(8'h52), ADDR_HI, ADDR_LO. Response: DATA_HI, DATA_LO.
  - Any other first byte: respond NAK_BYTE and return to IDLE.
- States and transitions:
  - IDLE: on rx, if cmd is valid, latch cmd and go to A_HI; otherwise go to TX_NAK.
  - A_HI to A_LO: collect the address bytes.
  - After A_LO: go to D_HI for 'W', or to REQ for 'R'.
  - D_HI, D_LO: collect the data bytes, then go to REQ.
  - REQ: assert `o_bus_req`. Wait for `i_bus_gnt`. On grant, go to ACCESS.
  - ACCESS (1 cycle): drive `o_bus_addr`; drive `o_bus_we` = 1 only for writes, with `o_bus_wdata` valid.
    - Write: next state TX_ACK.
    - Read: next state SAMPLE.
  - SAMPLE (1 cycle): hold `o_bus_addr` and `o_bus_we` = 0. Capture `i_bus_rdata` at the end of the cycle; this covers the 1-cycle synchronous RAM/ROM latency. Next state TX_HI.
  - TX_HI → TX_LO → IDLE, for a read.
  - TX_ACK → IDLE, for a write.
  - TX_NAK → IDLE.
- `o_bus_req`: asserted from entry to REQ until the last bus cycle (end of ACCESS for a write, end of SAMPLE for a read). Deasserted in the next cycle.
- `o_bus_we`: never high without `i_bus_gnt`. High for exactly one cycle per write.
- Bus drive outside ACCESS/SAMPLE: `o_bus_addr`, `o_bus_wdata` and `o_bus_we` are driven to 0.
- Grant loss: if `i_bus_gnt` drops during ACCESS/SAMPLE, the access is still considered complete. The arbiter must not revoke grant while `o_bus_req` = 1.
- Byte order: big-endian. HI byte is bits [15:8].
- TX handshake: `o_tx_valid` rises on state entry. `o_tx_data` is stable while valid. The state advances on the cycle where valid && ready. A long-low `i_tx_ready` stalls indefinitely.
- Dropped bytes: `i_rx_valid` in REQ, ACCESS, SAMPLE or any TX state → byte dropped, `o_overrun` pulses 1 cycle, parse state unaffected.
- Byte collection: an rx byte is consumed in the same cycle it is strobed. Back-to-back strobes on consecutive cycles are accepted.
- Reset mid-operation: everything returns immediately to reset values, including `o_bus_req` and `o_bus_we`. Partial frames are discarded.
- Address range: the full 16-bit address is passed through unchecked. Unmapped reads return whatever the SoC mux gives (0).

Optional Feature:
- Macro: BUS_DEBUG_BRIDGE_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on every consumed rx byte and increments each cycle in A_HI, A_LO, D_HI or D_LO.
  - When it reaches TIMEOUT_CYCLES-1, the frame is abandoned: go to TX_NAK, send NAK_BYTE, return to IDLE.
  - The counter is held at 0 in all other states.
- When undefined: no counter. A partial frame waits forever for its remaining bytes.

Test Plan:
- Write: rx 57 04 30 BE EF → one cycle with `o_bus_we`=1, addr 16'h0430, wdata 16'hBEEF while gnt=1; then tx 06.
- Read: preload RAM[16'h0010]=16'h1234, rx 52 00 10 → `o_bus_req` up, gnt after 3 cycles, then ACCESS + SAMPLE; tx 12 then 34, with `i_tx_ready` toggled low between bytes.
- Bad command: rx 8'hAA → tx 15, back in IDLE (`o_busy`=0); then a valid 'R' frame completes normally.
- Dropped byte: rx 8'h00 strobed during REQ with gnt held low → `o_overrun` pulse. After grant, the response still uses the originally latched address.
- Reset mid-transfer: assert `i_reset_n`=0 during ACCESS of a write → `o_bus_we` and `o_bus_req` fall asynchronously. After release, `o_busy`=0 and no tx byte is emitted.
- Timeout (macro defined, TIMEOUT_CYCLES=16): rx 57 04 then silence → tx 15 after 16 idle cycles. Without the macro, no tx after 1000 cycles.
